uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver. It consumes the receiver's RxDone/RxData outputs and stores each completed byte in a first-word-fall-through FIFO for the host or bus side. It carries RxDone, which is generated on the baud Tick, into the Clk domain. It also reports level, full, empty and a sticky overrun flag.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
RxDone  input  1  byte-complete flag from the receiver; Tick-domain level, high for at least one Tick period
RxData  input  8  received byte from the receiver; stable while RxDone is high
RdEn  input  1  pop request for the head entry
Flush  input  1  synchronous clear of FIFO contents
OvrClr  input  1  clears the Overrun flag
RdData  output  8  head entry; valid whenever Empty=0
Empty  output  1  FIFO holds no entries
Full  output  1  FIFO holds DEPTH entries
Level  output  ADDR_W+1  current entry count, 0..DEPTH
Overrun  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset is Rst_n, asynchronous, active-low; clock is Clk. All state updates on posedge Clk.
- Reset values: wr_ptr=0, rd_ptr=0, Level=0, Empty=1, Full=0, Overrun=0, synchroniser flops=0. Storage contents are not reset.
- RxDone passes through a 2-flop synchroniser (s1, s2) followed by a delay flop s3. The write strobe is wr_stb = s2 & ~s3: exactly one pulse per RxDone rising edge, however long RxDone stays high.
- On wr_stb, RxData is sampled in the same cycle. Latency from the first Clk edge that sees RxDone=1 to the entry appearing (Empty falling) is 3 cycles.
- Pointers are ADDR_W+1 bits. Address is ptr[ADDR_W-1:0] and wraps modulo DEPTH.
  - Full = (MSBs differ) & (low bits equal).
  - Empty = pointers equal.
  - Level = wr_ptr - rd_ptr, taken modulo 2^(ADDR_W+1).
  - All flags are registered or derived purely from registered pointers; none depends combinationally on inputs.
- RdData = mem[rd_ptr], first-word-fall-through. RdEn=1 with Empty=0 advances rd_ptr on the next edge. RdEn with Empty=1 is ignored; pointers and flags are unchanged.
- Write accepted when wr_stb & (~Full | pop), where pop = RdEn & ~Empty.
  - Full with simultaneous pop: the write is accepted, Level stays DEPTH, no overrun.
- Write dropped when wr_stb & Full & ~pop. Overrun is set on the next edge and FIFO contents are untouched.
- Empty FIFO with simultaneous wr_stb and RdEn: RdEn is ignored, because Empty was 1 at that edge. The byte is stored.
- Overrun priority: set beats OvrClr in the same cycle. Otherwise OvrClr=1 clears it.
- Flush=1: wr_ptr and rd_ptr both return to 0 on the next edge.
  - Flush beats wr_stb and RdEn in the same cycle; that byte is discarded and Overrun is not set by it.
  - Flush does not alter Overrun or the synchroniser.
- Reset mid-operation: all pointers, flags and synchroniser flops clear immediately. If RxDone is still high at reset release, s2 rises after 2 cycles and one spurious write occurs. This is accepted behaviour, because RxDone from the receiver is low after its own reset.

Optional Feature:
UART_RXF_LEVEL_IRQ_EN
- Defined: adds input Thresh [ADDR_W:0] and output LevelIrq.
  - LevelIrq is a registered flag: 1 when Thresh!=0 and Level >= Thresh, evaluated on the post-update Level, so it lags Level by one cycle.
  - Reset value 0. A Thresh value above DEPTH never asserts.
- Not defined: neither port exists and there is no threshold logic.

Test Plan:
- Reset, then hold RxDone=1 for 40 Clk cycles with RxData=8'hA5 -> exactly one write; Empty=0 three cycles after RxDone rises; RdData=8'hA5; Level=1.
- Write 8'h00..8'h0F (16 bytes, DEPTH=16), then pop 16 times -> Full=1 after the 16th write; pops return 00..0F in order; Empty=1 at the end; pointers have wrapped.
- Fill to 16, then send byte 8'hEE with no RdEn -> Overrun=1; Level stays 16; pops still return 00..0F; OvrClr=1 clears Overrun; OvrClr in the same cycle as a new drop leaves Overrun=1.
- Full FIFO, wr_stb coincides with RdEn -> Level stays 16, Overrun=0, last pop returns the new byte.
- Level=5, assert Flush in the same cycle as a wr_stb for 8'h3C -> Level=0, Empty=1, Overrun unchanged, 8'h3C never appears.
- With UART_RXF_LEVEL_IRQ_EN defined and Thresh=4: write 4 bytes -> LevelIrq rises one cycle after Level=4; one pop -> LevelIrq falls; Thresh=0 -> LevelIrq stays 0 even when full.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receive buffer and its neighbours: receiver-side byte strobe,
// host-side pop/flush/overrun-clear and status. Optional threshold signals exist under UART_RXF_LEVEL_IRQ_EN.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    // Pop handshake: RdData is valid whenever Empty=0; RdEn=1 with Empty=0 consumes the head on the next edge.
    logic              RxDone;
    logic [7:0]        RxData;
    logic              RdEn;
    logic              Flush;
    logic              OvrClr;
    logic [7:0]        RdData;
    logic              Empty;
    logic              Full;
    logic [ADDR_W:0]   Level;
    logic              Overrun;
`ifdef UART_RXF_LEVEL_IRQ_EN
    logic [ADDR_W:0]   Thresh;
    logic              LevelIrq;

    modport master (
        output RxDone, RxData, RdEn, Flush, OvrClr, Thresh,
        input  RdData, Empty, Full, Level, Overrun, LevelIrq
    );
    modport slave (
        input  RxDone, RxData, RdEn, Flush, OvrClr, Thresh,
        output RdData, Empty, Full, Level, Overrun, LevelIrq
    );
`else
    modport master (
        output RxDone, RxData, RdEn, Flush, OvrClr,
        input  RdData, Empty, Full, Level, Overrun
    );
    modport slave (
        input  RxDone, RxData, RdEn, Flush, OvrClr,
        output RdData, Empty, Full, Level, Overrun
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: synchronises RxDone into Clk, stores each byte in a first-word-fall-through FIFO
// and reports Level/Full/Empty/sticky Overrun. Define UART_RXF_LEVEL_IRQ_EN to add the Thresh/LevelIrq flag.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    uart_rx_fifo_if.slave bus
);
    typedef logic [ADDR_W:0] ptr_t;

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic       overrun_q, overrun_d;
    logic [7:0] mem_q [DEPTH];

    logic       wr_stb;
    logic       empty;
    logic       full;
    logic       pop;
    logic       wr_en;
    logic       drop;
    ptr_t       level;

    // Flags come only from registered pointers, never from the current inputs.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // RxDone lives in the Tick domain; s3 turns the synchronised level into one pulse per byte.
    assign wr_stb = s2_q & ~s3_q;
    assign pop    = bus.RdEn & ~empty;
    assign wr_en  = wr_stb & (~full | pop) & ~bus.Flush;
    assign drop   = wr_stb & full & ~pop & ~bus.Flush;

    always_comb begin
        s1_d      = bus.RxDone;
        s2_d      = s1_q;
        s3_d      = s2_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.OvrClr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.RxData;
    end

    assign bus.RdData  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign bus.Empty   = empty;
    assign bus.Full    = full;
    assign bus.Level   = level;
    assign bus.Overrun = overrun_q;

`ifdef UART_RXF_LEVEL_IRQ_EN
    logic level_irq_q, level_irq_d;

    // Compares the registered Level, so the flag trails Level by one cycle.
    always_comb begin
        level_irq_d = (bus.Thresh != '0) && (level >= bus.Thresh);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) level_irq_q <= 1'b0;
        else        level_irq_q <= level_irq_d;
    end

    assign bus.LevelIrq = level_irq_q;
`endif
endmodule
